// File: rtl/counter_ctrl_if.sv
// Configuration / run-control / status bundle for counter_ctrl; the optional cfg_div
// field exists only when COUNTER_CTRL_PRESCALE_EN is defined.
interface counter_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_limit;
    logic        cfg_periodic;
`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [7:0]  cfg_div;
`endif
    logic        start;
    logic        stop;
    logic [31:0] cnt_out;
    logic        busy;
    logic        done;
    logic [7:0]  period_cnt;

`ifdef COUNTER_CTRL_PRESCALE_EN
    modport master (
        output cfg_valid, cfg_limit, cfg_periodic, cfg_div, start, stop,
        input  cfg_ready, cnt_out, busy, done, period_cnt
    );
    modport slave (
        input  cfg_valid, cfg_limit, cfg_periodic, cfg_div, start, stop,
        output cfg_ready, cnt_out, busy, done, period_cnt
    );
`else
    modport master (
        output cfg_valid, cfg_limit, cfg_periodic, start, stop,
        input  cfg_ready, cnt_out, busy, done, period_cnt
    );
    modport slave (
        input  cfg_valid, cfg_limit, cfg_periodic, start, stop,
        output cfg_ready, cnt_out, busy, done, period_cnt
    );
`endif
endinterface

// File: rtl/counter_ctrl.sv
// Configurable one-shot / auto-reload counter FSM; optional prescaler under COUNTER_CTRL_PRESCALE_EN.
// Latency: count moves one cycle after RUN entry; config accepted only in IDLE/DONE (cfg_ready).
module counter_ctrl (
    input  logic           clk,
    input  logic           p_reset,
    counter_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  period_q, period_d;
    logic        done_q, done_d;
    logic [31:0] limit_q, limit_d;
    logic        periodic_q, periodic_d;
    logic        adv;

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [7:0]  div_q, div_d;
    logic [7:0]  presc_q, presc_d;

    assign adv = (presc_q == div_q);
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!p_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!p_reset) begin
            cnt_q      <= 32'd0;
            period_q   <= 8'd0;
            done_q     <= 1'b0;
            limit_q    <= 32'd0;
            periodic_q <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
            div_q      <= 8'd0;
            presc_q    <= 8'd0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            done_q     <= done_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
`ifdef COUNTER_CTRL_PRESCALE_EN
            div_q      <= div_d;
            presc_q    <= presc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        done_d     = 1'b0;
        limit_d    = limit_q;
        periodic_d = periodic_q;
`ifdef COUNTER_CTRL_PRESCALE_EN
        div_d      = div_q;
        presc_d    = presc_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.cfg_valid) begin
                    limit_d    = bus.cfg_limit;
                    periodic_d = bus.cfg_periodic;
                    cnt_d      = 32'd0;
                    period_d   = 8'd0;
                    state_d    = S_ARMED;
`ifdef COUNTER_CTRL_PRESCALE_EN
                    div_d      = bus.cfg_div;
                    presc_d    = 8'd0;
`endif
                end
            end

            S_ARMED: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // stop freezes everything, including a terminal count reached this cycle
                if (bus.stop) begin
                    state_d = S_HOLD;
                end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
                    presc_d = adv ? 8'd0 : presc_q + 8'd1;
`endif
                    if (adv) begin
                        if (cnt_q == limit_q) begin
                            done_d = 1'b1;
                            if (periodic_q) begin
                                cnt_d    = 32'd0;
                                period_d = period_q + 8'd1;
                            end else begin
                                state_d  = S_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    state_d = S_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
                    presc_d = 8'd0;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cnt_out    = cnt_q;
    assign bus.period_cnt = period_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q == S_RUN) || (state_q == S_HOLD);
    assign bus.cfg_ready  = (state_q == S_IDLE) || (state_q == S_DONE);

endmodule
